// File: rtl/vec_issue_ctrl.sv
// Vector instruction issue controller: accepts one decoded op, starts the exec unit, waits for done, hands result to writeback.
// Optional BUSY watchdog enabled by defining VEC_CTRL_TIMEOUT_EN.
module vec_issue_ctrl #(
  parameter int VLEN    = 256,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [5:0]      issue_funct6,
  input  logic [2:0]      issue_vsew,
  input  logic [1:0]      issue_src,
  input  logic [4:0]      issue_vd,
  output logic            exec_start,
  output logic [5:0]      exec_funct6,
  output logic [2:0]      exec_vsew,
  output logic [1:0]      exec_src,
  input  logic            exec_done,
  input  logic [VLEN-1:0] exec_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_vd,
  output logic [VLEN-1:0] wb_data,
  output logic            stall,
  output logic            busy,
  output logic [15:0]     op_cycles,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cyc_cnt;
  logic        accept;
  logic        done_hit;
  logic        tmo_hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign issue_ready = (state == IDLE);
  assign stall       = issue_valid & ~issue_ready;
  assign busy        = (state != IDLE);
  assign exec_start  = (state == START);
  assign wb_valid    = (state == WB);
  assign accept      = issue_ready & issue_valid;
  // done is only meaningful in BUSY; in START it is still the previous op's level
  assign done_hit    = (state == BUSY) & exec_done;

`ifdef VEC_CTRL_TIMEOUT_EN
  assign tmo_hit = (state == BUSY) & ~exec_done & (cyc_cnt == 16'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (tmo_hit) begin
      err <= 1'b1;
    end
  end
`else
  localparam int tmo_unused = TIMEOUT;
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_valid) state_nxt = START;
      START:   state_nxt = BUSY;
      BUSY: begin
        if (exec_done)    state_nxt = WB;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WB:      if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // control: state and BUSY cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cyc_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == START) begin
        cyc_cnt <= 16'd1;
      end else if (state == BUSY) begin
        cyc_cnt <= sat_inc16(cyc_cnt);
      end
    end
  end

  // operand latch on accept, result capture on done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exec_funct6 <= 6'd0;
      exec_vsew   <= 3'd0;
      exec_src    <= 2'd0;
      wb_vd       <= 5'd0;
      wb_data     <= '0;
      op_cycles   <= 16'd0;
    end else begin
      if (accept) begin
        exec_funct6 <= issue_funct6;
        exec_vsew   <= issue_vsew;
        exec_src    <= issue_src;
        wb_vd       <= issue_vd;
      end
      if (done_hit) begin
        wb_data   <= exec_result;
        op_cycles <= cyc_cnt;
      end else if (tmo_hit) begin
        op_cycles <= 16'(TIMEOUT);
      end
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl with a behavioural exec-unit model.
module tb_vec_issue_ctrl;
  localparam int VLEN = 256;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            issue_valid;
  logic            issue_ready;
  logic [5:0]      issue_funct6;
  logic [2:0]      issue_vsew;
  logic [1:0]      issue_src;
  logic [4:0]      issue_vd;
  logic            exec_start;
  logic [5:0]      exec_funct6;
  logic [2:0]      exec_vsew;
  logic [1:0]      exec_src;
  logic            exec_done;
  logic [VLEN-1:0] exec_result;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_vd;
  logic [VLEN-1:0] wb_data;
  logic            stall;
  logic            busy;
  logic [15:0]     op_cycles;
  logic            err;

  always #5 clk = ~clk;

  vec_issue_ctrl #(.VLEN(VLEN), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct6(issue_funct6), .issue_vsew(issue_vsew),
    .issue_src(issue_src), .issue_vd(issue_vd),
    .exec_start(exec_start), .exec_funct6(exec_funct6),
    .exec_vsew(exec_vsew), .exec_src(exec_src),
    .exec_done(exec_done), .exec_result(exec_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_vd(wb_vd), .wb_data(wb_data),
    .stall(stall), .busy(busy), .op_cycles(op_cycles), .err(err)
  );

  typedef struct {
    logic [4:0]      vd;
    logic [VLEN-1:0] data;
    logic [15:0]     cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // exec unit model: done rises m_lat cycles after the start cycle and stays high
  // until the cycle after the next start; m_lat == 0 means never done
  int              m_lat = 1;
  logic [VLEN-1:0] m_res = '0;
  initial begin
    int              mc;
    int              lat_l;
    bit              mact;
    logic [VLEN-1:0] res_l;
    mc = 0; lat_l = 0; mact = 0; res_l = '0;
    exec_done   = 1'b0;
    exec_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        mact      = 0;
        exec_done = 1'b0;
      end else if (exec_start) begin
        mact  = 1;
        mc    = 0;
        lat_l = m_lat;
        res_l = m_res;
      end else if (mact) begin
        mc++;
        if (mc == 1) exec_done = 1'b0;
        if (lat_l > 0 && mc >= lat_l) begin
          exec_done   = 1'b1;
          exec_result = res_l;
        end
      end
    end
  end

  // writeback monitor: every handshake must match the oldest issued op
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && wb_valid && wb_ready) begin
      chk("sb_has_entry", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_vd", wb_vd, e.vd);
        chk("sb_data", wb_data, e.data);
        chk("sb_cycles", op_cycles, e.cyc);
      end
    end
  end

  task automatic drive_issue(input logic [5:0] f6, input logic [2:0] sew,
                             input logic [1:0] src, input logic [4:0] vd);
    issue_valid  = 1'b1;
    issue_funct6 = f6;
    issue_vsew   = sew;
    issue_src    = src;
    issue_vd     = vd;
  endtask

  task automatic drive_junk;
    issue_valid  = 1'b1;
    issue_funct6 = 6'($urandom);
    issue_vsew   = 3'($urandom);
    issue_src    = 2'($urandom);
    issue_vd     = 5'($urandom);
  endtask

  task automatic run_op(input logic [5:0] f6, input logic [2:0] sew, input logic [1:0] src,
                        input logic [4:0] vd, input int lat, input int backp);
    int              n;
    logic [VLEN-1:0] d;
    logic [VLEN-1:0] held;
    n = 0;
    while (!issue_ready && n < 50) begin tick; n++; end
    chk("ready_wait", issue_ready, 1);
    d     = rand_vec();
    m_lat = lat;
    m_res = d;
    exp_q.push_back('{vd, d, 16'(lat)});
    drive_issue(f6, sew, src, vd);
    chk("stall_idle", stall, 0);
    tick;
    chk("start_pulse", exec_start, 1);
    chk("start_busy", busy, 1);
    chk("start_stall", stall, 1);
    chk("ex_funct6", exec_funct6, f6);
    chk("ex_vsew", exec_vsew, sew);
    chk("ex_src", exec_src, src);
    n = 0;
    do begin
      drive_junk();
      tick;
      n++;
      chk("start_once", exec_start, 0);
      chk("ex_funct6_hold", exec_funct6, f6);
      chk("ex_src_hold", exec_src, src);
    end while (!wb_valid && n < lat + 10);
    issue_valid = 1'b0;
    chk("wb_latency", n, lat + 1);
    chk("wb_vd", wb_vd, vd);
    chk("wb_cycles", op_cycles, lat);
    chk("wb_data", wb_data, d);
    chk("wb_not_ready", issue_ready, 0);
    held = wb_data;
    if (backp > 0) begin
      wb_ready = 1'b0;
      for (int i = 0; i < backp; i++) begin
        drive_junk();
        tick;
        chk("bp_valid", wb_valid, 1);
        chk("bp_data", wb_data, held);
        chk("bp_vd", wb_vd, vd);
        chk("bp_stall", stall, 1);
      end
      issue_valid = 1'b0;
      wb_ready    = 1'b1;
    end
    tick;
    chk("post_wb_valid", wb_valid, 0);
    chk("post_wb_ready", issue_ready, 1);
    chk("post_wb_busy", busy, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, exec_start, 0);
    chk({tag, "_funct6"}, exec_funct6, 0);
    chk({tag, "_vsew"}, exec_vsew, 0);
    chk({tag, "_src"}, exec_src, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wbvd"}, wb_vd, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_opcyc"}, op_cycles, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, issue_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    reset_n      = 1'b0;
    issue_valid  = 1'b0;
    issue_funct6 = '0;
    issue_vsew   = '0;
    issue_src    = '0;
    issue_vd     = '0;
    wb_ready     = 1'b1;
    tick; tick; tick;
    chk_reset_outs("rst");
    drive_issue(6'h11, 3'b001, 2'b01, 5'd9);
    chk("rst_stall", stall, 0);

    reset_n     = 1'b1;
    issue_valid = 1'b0;
    run_op(6'h00, 3'b010, 2'b00, 5'd3, 3, 0);
    run_op(6'h2A, 3'b001, 2'b10, 5'd7, 4, 0);
    run_op(6'h15, 3'b000, 2'b01, 5'd12, 2, 4);

    m_lat = 6;
    m_res = rand_vec();
    drive_issue(6'h05, 3'b011, 2'b00, 5'd20);
    tick;
    issue_valid = 1'b0;
    tick; tick;
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    tick; tick;
    chk_reset_outs("arst_hold");
    reset_n = 1'b1;
    run_op(6'h3F, 3'b011, 2'b00, 5'd31, 5, 0);

`ifdef VEC_CTRL_TIMEOUT_EN
    m_lat = 0;
    drive_issue(6'h01, 3'b000, 2'b00, 5'd4);
    tick;
    issue_valid = 1'b0;
    chk("tmo_start", exec_start, 1);
    n = 0;
    do begin
      tick;
      n++;
      chk("tmo_no_wb", wb_valid, 0);
    end while (busy && n < 40);
    chk("tmo_len", n, TMO + 1);
    chk("tmo_err", err, 1);
    chk("tmo_opcyc", op_cycles, TMO);
    chk("tmo_idle", issue_ready, 1);
    run_op(6'h0C, 3'b010, 2'b01, 5'd8, 1, 0);
    chk("tmo_err_sticky", err, 1);
`else
    run_op(6'h0C, 3'b010, 2'b01, 5'd8, 1, 0);
    chk("no_wdog_err", err, 0);
`endif

    tick;
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
